// File: rtl/sys_defs_pkg.sv
// Shared core definitions: physical register file sizing and FU function codes.
package sys_defs;
   localparam int NUM_PHYS_REG   = 64;
   localparam int PHYS_REG_TAG_W = $clog2(NUM_PHYS_REG);

   typedef enum logic {
      MULQ  = 1'b0,
      UMULH = 1'b1
   } mult_func_t;
endpackage

// File: rtl/mult_stage.sv
// One radix-2^STAGE_BITS partial-product step of the pipelined multiplier plus its register.
module mult_stage
   import sys_defs::*;
#(
   parameter int XLEN       = 64,
   parameter int STAGE_BITS = 16,
   parameter int STAGE_IDX  = 0,
   parameter int TAG_W      = PHYS_REG_TAG_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              squash,
   input  logic              advance,
   input  logic              prev_valid,
   input  mult_func_t        prev_func,
   input  logic [TAG_W-1:0]  prev_tag,
   input  logic [XLEN-1:0]   prev_opa,
   input  logic [XLEN-1:0]   prev_opb,
   input  logic [2*XLEN-1:0] prev_acc,
   output logic              valid,
   output mult_func_t        func,
   output logic [TAG_W-1:0]  tag,
   output logic [XLEN-1:0]   opa,
   output logic [XLEN-1:0]   opb,
   output logic [2*XLEN-1:0] acc
);
   localparam int SHIFT = STAGE_IDX * STAGE_BITS;

   logic [2*XLEN-1:0] pp;

   // opb arrives pre-shifted, so its low slice is always this stage's digit
   assign pp = ({{XLEN{1'b0}}, prev_opa} *
                {{(2*XLEN-STAGE_BITS){1'b0}}, prev_opb[STAGE_BITS-1:0]}) << SHIFT;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)       valid <= 1'b0;
      else if (squash)  valid <= 1'b0;
      else if (advance) valid <= prev_valid;
   end

   // Payload is only meaningful under valid, so it carries no reset
   always_ff @(posedge clock) begin
      if (advance) begin
         func <= prev_func;
         tag  <= prev_tag;
         opa  <= prev_opa;
         opb  <= prev_opb >> STAGE_BITS;
         acc  <= prev_acc + pp;
      end
   end
endmodule

// File: rtl/mult_fu.sv
// Pipelined unsigned multiply functional unit (MULQ / UMULH) with CDB backpressure and squash.
module mult_fu
   import sys_defs::*;
#(
   parameter int XLEN       = 64,
   parameter int NUM_STAGES = 4,
   parameter int TAG_W      = PHYS_REG_TAG_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [XLEN-1:0]  in_opa,
   input  logic [XLEN-1:0]  in_opb,
   input  logic             in_func,
   input  logic [TAG_W-1:0] in_dest_tag,
   input  logic             squash,
   input  logic             cdb_gnt,
   output logic             issue_stall,
   output logic             out_valid,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_dest_tag
);
   // NUM_STAGES must divide XLEN evenly
   localparam int STAGE_BITS = XLEN / NUM_STAGES;

   // Index 0 is the issue port; index k+1 is the register of stage k
   logic       [NUM_STAGES:0]             vld_pipe;
   mult_func_t [NUM_STAGES:0]             func_pipe;
   logic       [NUM_STAGES:0][TAG_W-1:0]  tag_pipe;
   logic       [NUM_STAGES:0][XLEN-1:0]   opa_pipe;
   logic       [NUM_STAGES:0][XLEN-1:0]   opb_pipe;
   logic       [NUM_STAGES:0][2*XLEN-1:0] acc_pipe;
   logic       [NUM_STAGES-1:0]           advance;
   logic                                  unused_tail;

   assign vld_pipe[0]  = in_valid;
   assign func_pipe[0] = mult_func_t'(in_func);
   assign tag_pipe[0]  = in_dest_tag;
   assign opa_pipe[0]  = in_opa;
   assign opb_pipe[0]  = in_opb;
   assign acc_pipe[0]  = '0;

   // Backpressure ripples from the CDB toward issue through empty slots
   assign advance[NUM_STAGES-1] = ~vld_pipe[NUM_STAGES] | cdb_gnt;
   for (genvar k = 0; k < NUM_STAGES-1; k++) begin : g_adv
      assign advance[k] = ~vld_pipe[k+1] | advance[k+1];
   end

   assign issue_stall = vld_pipe[1] & ~advance[0];

   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      mult_stage #(
         .XLEN(XLEN), .STAGE_BITS(STAGE_BITS), .STAGE_IDX(k), .TAG_W(TAG_W)
      ) u_stage (
         .clock      (clock),
         .reset      (reset),
         .squash     (squash),
         .advance    (advance[k]),
         .prev_valid (vld_pipe[k]),
         .prev_func  (func_pipe[k]),
         .prev_tag   (tag_pipe[k]),
         .prev_opa   (opa_pipe[k]),
         .prev_opb   (opb_pipe[k]),
         .prev_acc   (acc_pipe[k]),
         .valid      (vld_pipe[k+1]),
         .func       (func_pipe[k+1]),
         .tag        (tag_pipe[k+1]),
         .opa        (opa_pipe[k+1]),
         .opb        (opb_pipe[k+1]),
         .acc        (acc_pipe[k+1])
      );
   end

   assign unused_tail = ^{opa_pipe[NUM_STAGES], opb_pipe[NUM_STAGES]};

   // Outputs are gated so an empty FU never shows stale payload
   assign out_valid    = vld_pipe[NUM_STAGES];
   assign out_dest_tag = out_valid ? tag_pipe[NUM_STAGES] : '0;
   assign out_result   = !out_valid                   ? '0 :
                         (func_pipe[NUM_STAGES] == UMULH) ? acc_pipe[NUM_STAGES][2*XLEN-1:XLEN]
                                                          : acc_pipe[NUM_STAGES][XLEN-1:0];
endmodule

// File: tb/tb_mult_fu.sv
// Directed bench for mult_fu: scoreboard of expected products checked as results leave on the CDB.
module tb_mult_fu;
   import sys_defs::*;
   localparam int XLEN = 64;
   localparam int TW   = PHYS_REG_TAG_W;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic            in_valid = 1'b0;
   logic [XLEN-1:0] in_opa = '0;
   logic [XLEN-1:0] in_opb = '0;
   logic            in_func = 1'b0;
   logic [TW-1:0]   in_dest_tag = '0;
   logic            squash = 1'b0;
   logic            cdb_gnt = 1'b0;
   logic            issue_stall;
   logic            out_valid;
   logic [XLEN-1:0] out_result;
   logic [TW-1:0]   out_dest_tag;

   mult_fu #(.XLEN(XLEN), .NUM_STAGES(4), .TAG_W(TW)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_opa(in_opa), .in_opb(in_opb),
      .in_func(in_func), .in_dest_tag(in_dest_tag), .squash(squash), .cdb_gnt(cdb_gnt),
      .issue_stall(issue_stall), .out_valid(out_valid), .out_result(out_result),
      .out_dest_tag(out_dest_tag)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [TW-1:0]   tag;
      logic [XLEN-1:0] res;
   } exp_t;

   exp_t sb[$];
   int   pop_cyc[$];
   int   cyc = 0;
   int   nvec = 0;
   int   nerr = 0;
   exp_t mon_e;

   always @(posedge clock) cyc++;

   task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   function automatic logic [XLEN-1:0] model(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                             input logic f);
      logic [2*XLEN-1:0] p;
      p = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
      return f ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
   endfunction

   // A result is committed when it is granted at the next edge without a squash
   always @(negedge clock) begin
      if (reset && out_valid && cdb_gnt && !squash) begin
         pop_cyc.push_back(cyc);
         chk("sb_nonempty", 128'(sb.size() != 0), 128'(1));
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("result", 128'(out_result), 128'(mon_e.res));
            chk("tag", 128'(out_dest_tag), 128'(mon_e.tag));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic drive(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic f,
                        input logic [TW-1:0] tag, input logic exp_stall, input logic push);
      exp_t e;
      in_valid = 1'b1; in_opa = a; in_opb = b; in_func = f; in_dest_tag = tag;
      chk("issue_stall", 128'(issue_stall), 128'(exp_stall));
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      if (push) begin
         e.tag = tag;
         e.res = model(a, b, f);
         sb.push_back(e);
      end
   endtask

   task automatic drain(input int max);
      for (int i = 0; i < max && sb.size() != 0; i++) tick(1);
      chk("drain_timeout", 128'(sb.size()), 128'(0));
      tick(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [XLEN-1:0] a, b;
      logic [XLEN-1:0] ones;
      ones = '1;

      // reset state
      tick(2);
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_issue_stall", 128'(issue_stall), 128'(0));
      chk("rst_out_result", 128'(out_result), 128'(0));
      chk("rst_out_tag", 128'(out_dest_tag), 128'(0));
      reset = 1'b1;
      tick(1);

      // single MULQ latency and single-cycle result
      cdb_gnt = 1'b1;
      drive(64'd3, 64'd5, 1'b0, 6'd7, 1'b0, 1'b1);
      chk("lat_e0", 128'(out_valid), 128'(0));
      tick(1);
      chk("lat_e1", 128'(out_valid), 128'(0));
      tick(1);
      chk("lat_e2", 128'(out_valid), 128'(0));
      tick(1);
      chk("lat_e3_valid", 128'(out_valid), 128'(1));
      chk("lat_e3_result", 128'(out_result), 128'(15));
      chk("lat_e3_tag", 128'(out_dest_tag), 128'(7));
      tick(1);
      chk("lat_e4_valid", 128'(out_valid), 128'(0));

      // all-ones operands, both halves
      drive(ones, ones, 1'b1, 6'd1, 1'b0, 1'b1);
      drive(ones, ones, 1'b0, 6'd2, 1'b0, 1'b1);
      tick(2);
      chk("umulh_valid", 128'(out_valid), 128'(1));
      chk("umulh_ones", 128'(out_result), 128'(64'hFFFF_FFFF_FFFF_FFFE));
      tick(1);
      chk("mulq_ones", 128'(out_result), 128'(64'h1));
      drain(10);

      // back-to-back throughput
      pop_cyc.delete();
      for (int i = 0; i < 8; i++) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         drive(a, b, i[0], TW'(i + 8), 1'b0, 1'b1);
      end
      drain(20);
      chk("b2b_count", 128'(pop_cyc.size()), 128'(8));
      for (int i = 1; i < 8 && i < pop_cyc.size(); i++)
         chk("b2b_consecutive", 128'(pop_cyc[i] - pop_cyc[0]), 128'(i));

      // CDB backpressure: 4 fill the pipe, 5th is dropped
      cdb_gnt = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         drive(a, b, i[1], TW'(i + 20), 1'b0, 1'b1);
      end
      drive(64'd11, 64'd13, 1'b0, 6'd30, 1'b1, 1'b0);
      chk("hold_valid", 128'(out_valid), 128'(1));
      chk("hold_result", 128'(out_result), 128'(sb[0].res));
      tick(2);
      chk("hold_result_stable", 128'(out_result), 128'(sb[0].res));
      chk("hold_tag_stable", 128'(out_dest_tag), 128'(sb[0].tag));
      chk("hold_stall", 128'(issue_stall), 128'(1));
      pop_cyc.delete();
      cdb_gnt = 1'b1;
      drain(20);
      tick(4);
      chk("bp_drain_count", 128'(pop_cyc.size()), 128'(4));
      chk("bp_empty", 128'(out_valid), 128'(0));

      // squash with 3 in flight plus a same-cycle issue
      for (int i = 0; i < 3; i++) drive(64'(i + 2), 64'd9, 1'b0, TW'(i + 40), 1'b0, 1'b0);
      in_valid = 1'b1; in_opa = 64'd77; in_opb = 64'd3; in_dest_tag = 6'd50; squash = 1'b1;
      tick(1);
      in_valid = 1'b0; squash = 1'b0;
      chk("squash_stall", 128'(issue_stall), 128'(0));
      for (int i = 0; i < 5; i++) begin
         chk("squash_quiet", 128'(out_valid), 128'(0));
         tick(1);
      end
      drive(64'd6, 64'd7, 1'b0, 6'd3, 1'b0, 1'b1);
      drain(10);

      // asynchronous reset mid-pipeline
      cdb_gnt = 1'b0;
      for (int i = 0; i < 4; i++) drive(64'(i + 100), 64'(i + 5), 1'b0, TW'(i + 60), 1'b0, 1'b1);
      chk("pre_rst_valid", 128'(out_valid), 128'(1));
      chk("pre_rst_stall", 128'(issue_stall), 128'(1));
      #3;
      reset = 1'b0;
      #1;
      chk("async_rst_valid", 128'(out_valid), 128'(0));
      chk("async_rst_stall", 128'(issue_stall), 128'(0));
      chk("async_rst_result", 128'(out_result), 128'(0));
      sb.delete();
      tick(1);
      #2;
      reset = 1'b1;
      cdb_gnt = 1'b1;
      tick(1);
      for (int i = 0; i < 6; i++) begin
         chk("post_rst_quiet", 128'(out_valid), 128'(0));
         tick(1);
      end
      drive(64'd9, 64'd9, 1'b0, 6'd5, 1'b0, 1'b1);
      drain(10);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/mult_fu.md
MULT_FU -- requirements
Module: mult_fu

Interface
REQ-001 Parameter XLEN, default 64, operand/result width.
REQ-002 Parameter NUM_STAGES, default 4, pipeline depth; SHALL divide XLEN evenly; STAGE_BITS = XLEN/NUM_STAGES.
REQ-003 Parameter TAG_W, default $clog2(`NUM_PHYS_REG), physical-register tag width.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  RS issues a multiply this cycle (issue_out slot for the mult FU is valid).
REQ-007 in_opa, in_opb  in  XLEN each  operands.
REQ-008 in_func  in  1  0 = MULQ (low XLEN bits of product), 1 = UMULH (high XLEN bits, unsigned).
REQ-009 in_dest_tag  in  TAG_W  destination physical register.
REQ-010 squash  in  1  branch mispredict flush, same meaning as the RS branch_not_taken.
REQ-011 cdb_gnt  in  1  CDB arbiter accepts the result presented this cycle.
REQ-012 issue_stall  out  1  RS SHALL NOT issue to this FU this cycle.
REQ-013 out_valid  out  1  result present, waiting for CDB.
REQ-014 out_result  out  XLEN  selected product half.
REQ-015 out_dest_tag  out  TAG_W  tag broadcast with result.

Function
REQ-016 Pipeline of NUM_STAGES registered stages; each stage holds valid, func, dest_tag, opa, remaining opb, 2*XLEN partial-product accumulator.
REQ-017 Stage k adds (opa * opb[STAGE_BITS-1:0]) << (k*STAGE_BITS) into the accumulator, unsigned, 2*XLEN width, carries kept, then shifts opb right by STAGE_BITS.
REQ-018 Final stage drives out_valid/out_result/out_dest_tag; out_result = acc[XLEN-1:0] for MULQ, acc[2*XLEN-1:XLEN] for UMULH.
REQ-019 Final stage advances (clears or takes the next op) when out_valid & cdb_gnt, or when empty.
REQ-020 Stage k < NUM_STAGES-1 advances iff stage k+1 is empty or advancing; a non-advancing valid stage holds its contents.
REQ-021 issue_stall = stage0.valid & ~advance0; purely combinational, no input-to-output register.
REQ-022 in_valid sampled at a rising edge loads stage0 iff issue_stall is low; in_valid while issue_stall is high is dropped, no error flagged.
REQ-023 Unstalled latency: op sampled at edge N gives out_valid high after edge N+NUM_STAGES-1 (visible in the cycle after edge N+NUM_STAGES-1); throughput one op per cycle.
REQ-024 out_valid held with stable result and tag until cdb_gnt; cdb_gnt with out_valid low is ignored.
REQ-025 squash high at an edge clears every stage valid bit; in_valid in the same cycle is discarded; issue_stall is low the cycle after.
REQ-026 Squash takes priority over cdb_gnt and advance in the same cycle; the result presented that cycle is not counted as committed by this block.
REQ-027 Datapath registers of invalid stages are don't-care; only valid bits need reset.

Reset
REQ-028 reset low asynchronously clears all stage valid bits; out_valid = 0, issue_stall = 0, out_result = 0, out_dest_tag = 0 while reset is asserted and until the first load.
REQ-029 Reset asserted mid-operation drops all in-flight ops; no output glitch to valid after reset deassertion.

Structure
REQ-030 The MULT_FUNC enum (MULQ, UMULH) and the PHYS_REG tag width come from the shared sys_defs package; no local redefinition.
REQ-031 One sub-module, mult_stage: one partial-product step plus its register, instantiated NUM_STAGES times by a generate loop.

Verification
REQ-032 Single MULQ, opa=3, opb=5, tag=7, cdb_gnt tied 1 -> out_valid for exactly one cycle after 4 edges, out_result=15, out_dest_tag=7.
REQ-033 UMULH opa=opb=64'hFFFF_FFFF_FFFF_FFFF -> out_result=64'hFFFF_FFFF_FFFF_FFFE; MULQ on the same operands -> 64'h1.
REQ-034 Back-to-back 8 ops, cdb_gnt=1 -> 8 results on 8 consecutive cycles, in order, issue_stall never high.
REQ-035 cdb_gnt=0 with 5 ops issued -> pipe fills with 4, issue_stall high from the 5th attempt; 5th dropped; raising cdb_gnt drains 4 in order.
REQ-036 squash with 3 ops in flight plus in_valid that cycle -> no out_valid for following 5 cycles; next op completes normally.
REQ-037 reset low mid-pipeline, off clock edge -> out_valid and issue_stall drop immediately; no stale result after release.
